reset_sequencer: RTL

- Sequences system reset release and the slow clock-enable for the BF CPU system, downstream of the clock/reset generator.
- Holds all reset domains asserted for a fixed time, then releases them one stage at a time in order: memory, then I/O, then core.
- Accepts soft-reset requests from several requesters (debug UART, watchdog, front-panel button), arbitrates them by fixed priority and records the reset cause.
- Generates a single-cycle slow clock-enable strobe while the system runs; no derived clocks.

---
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release, soft-reset arbitration, reset-cause
// capture and slow clock-enable strobe generation for the BF CPU system.
//
// After any reset event every stage is held asserted for HOLD cycles. The
// stages are then released one at a time, GAP cycles apart, starting with
// bit 0. Once all stages are released the block sits in RUN. In RUN it
// produces the slow enable and accepts soft-reset requests.
module reset_sequencer #(
  parameter int STAGES = 3,
  parameter int HOLD   = 16,
  parameter int GAP    = 4,
  parameter int NREQ   = 2,
  parameter int CE_DIV = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   SOFT_RST_REQ,
  output logic [NREQ-1:0]   SOFT_RST_ACK,
  output logic [STAGES-1:0] RST_OUT,
  output logic              BUSY,
  output logic              CE_SLOW,
  output logic [NREQ:0]     RST_CAUSE
);

  // Counter widths. Each width is at least one bit so that degenerate
  // parameter values still elaborate.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
  localparam logic [SW-1:0] IDX_LAST  = SW'(STAGES - 1);
  localparam logic [SW-1:0] IDX_FIRST = SW'(1);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [HW-1:0]       hold_cnt, hold_next;
  logic [GW-1:0]       gap_cnt, gap_next;
  logic [SW-1:0]       stage_idx, stage_idx_next;
  logic [CE_DIV-1:0]   ce_cnt, ce_cnt_next;

  logic [STAGES-1:0]   rst_out_next;
  logic                busy_next;
  logic                ce_slow_next;
  logic [NREQ-1:0]     ack_next;
  logic [NREQ:0]       cause_next;

  // One-hot winner among the pending requests. The lowest index has the
  // highest priority.
  logic [NREQ-1:0]     win_onehot;

  // Fixed-priority pick of the lowest-numbered active requester.
  always_comb begin
    win_onehot = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (SOFT_RST_REQ[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the sequencer. Outputs are
  // registered together with the state.
  always_comb begin
    state_next     = state;
    hold_next      = hold_cnt;
    gap_next       = gap_cnt;
    stage_idx_next = stage_idx;
    ce_cnt_next    = '0;
    rst_out_next   = RST_OUT;
    busy_next      = BUSY;
    ce_slow_next   = 1'b0;
    ack_next       = '0;
    cause_next     = RST_CAUSE;

    case (state)
      ASSERT: begin
        if (hold_cnt == HOLD_LAST) begin
          rst_out_next[0] = 1'b0;
          hold_next       = '0;
          gap_next        = '0;
          if (STAGES == 1) begin
            busy_next  = 1'b0;
            state_next = RUN;
          end else begin
            stage_idx_next = IDX_FIRST;
            state_next     = RELEASE;
          end
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end

      RELEASE: begin
        if (gap_cnt == GAP_LAST) begin
          for (int k = 0; k < STAGES; k++) begin
            if (SW'(k) == stage_idx) begin
              rst_out_next[k] = 1'b0;
            end
          end
          gap_next = '0;
          if (stage_idx == IDX_LAST) begin
            busy_next      = 1'b0;
            stage_idx_next = '0;
            state_next     = RUN;
          end else begin
            stage_idx_next = stage_idx + 1'b1;
          end
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end

      RUN: begin
        if (SOFT_RST_REQ != '0) begin
          // A granted soft reset re-enters the hold phase. The slow-enable
          // strobe is suppressed on the grant edge.
          ack_next       = win_onehot;
          cause_next     = {win_onehot, 1'b0};
          rst_out_next   = '1;
          busy_next      = 1'b1;
          hold_next      = '0;
          gap_next       = '0;
          stage_idx_next = '0;
          state_next     = ASSERT;
        end else begin
          ce_cnt_next  = ce_cnt + 1'b1;
          ce_slow_next = (ce_cnt == '1);
        end
      end

      default: begin
        rst_out_next = '1;
        busy_next    = 1'b1;
        hold_next    = '0;
        gap_next     = '0;
        state_next   = ASSERT;
      end
    endcase
  end

  // State, counter and output registers. A hard reset returns everything
  // to the start of the hold phase and records cause bit 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ASSERT;
      hold_cnt     <= '0;
      gap_cnt      <= '0;
      stage_idx    <= '0;
      ce_cnt       <= '0;
      RST_OUT      <= '1;
      BUSY         <= 1'b1;
      CE_SLOW      <= 1'b0;
      SOFT_RST_ACK <= '0;
      RST_CAUSE    <= {{NREQ{1'b0}}, 1'b1};
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      gap_cnt      <= gap_next;
      stage_idx    <= stage_idx_next;
      ce_cnt       <= ce_cnt_next;
      RST_OUT      <= rst_out_next;
      BUSY         <= busy_next;
      CE_SLOW      <= ce_slow_next;
      SOFT_RST_ACK <= ack_next;
      RST_CAUSE    <= cause_next;
    end
  end

endmodule
